// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and visible-window bounds shared
// by the timing generator and the render blocks.
package vga_timing_pkg;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam int unsigned H_VIS_START = H_SYNC + H_BP;
  localparam int unsigned H_VIS_END   = H_VIS_START + H_ACTIVE - 1;
  localparam int unsigned V_VIS_START = V_SYNC + V_BP;
  localparam int unsigned V_VIS_END   = V_VIS_START + V_ACTIVE - 1;

  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to render blocks and connector.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic pix_en;
  cnt_t hCount;
  cnt_t vCount;
  logic bright;
  logic hSync;
  logic vSync;
  logic frame_tick;

  modport master (output pix_en, hCount, vCount, bright, hSync, vSync, frame_tick);
  modport slave  (input  pix_en, hCount, vCount, bright, hSync, vSync, frame_tick);
endinterface

// File: rtl/vga_pix_div.sv
// Clock-enable divider: registered one-clk pix_en pulse every CLK_DIV clocks.
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en_o
);
  localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_en_q, pix_en_d;
  logic          wrap;

  assign wrap = (div_cnt_q == LAST);

  always_comb begin
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    pix_en_d  = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      pix_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= pix_en_d;
    end
  end

  assign pix_en_o = pix_en_q;
endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: pixel divider, h/v counters,
// zero-latency sync/bright decode and a registered per-frame strobe.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned P_CLK_DIV  = CLK_DIV,
  parameter int unsigned P_H_SYNC   = H_SYNC,
  parameter int unsigned P_H_BP     = H_BP,
  parameter int unsigned P_H_ACTIVE = H_ACTIVE,
  parameter int unsigned P_H_FP     = H_FP,
  parameter int unsigned P_V_SYNC   = V_SYNC,
  parameter int unsigned P_V_BP     = V_BP,
  parameter int unsigned P_V_ACTIVE = V_ACTIVE,
  parameter int unsigned P_V_FP     = V_FP
) (
  input logic clk,
  input logic rst,
  vga_timing_gen_if.master vga
);
  localparam int unsigned HT = P_H_SYNC + P_H_BP + P_H_ACTIVE + P_H_FP;
  localparam int unsigned VT = P_V_SYNC + P_V_BP + P_V_ACTIVE + P_V_FP;

  localparam cnt_t H_LAST  = cnt_t'(HT - 1);
  localparam cnt_t V_LAST  = cnt_t'(VT - 1);
  localparam cnt_t H_SYNCW = cnt_t'(P_H_SYNC);
  localparam cnt_t V_SYNCW = cnt_t'(P_V_SYNC);
  localparam cnt_t H_VS    = cnt_t'(P_H_SYNC + P_H_BP);
  localparam cnt_t H_VE    = cnt_t'(P_H_SYNC + P_H_BP + P_H_ACTIVE - 1);
  localparam cnt_t V_VS    = cnt_t'(P_V_SYNC + P_V_BP);
  localparam cnt_t V_VE    = cnt_t'(P_V_SYNC + P_V_BP + P_V_ACTIVE - 1);

  logic pix_en;
  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic frame_tick_q, frame_tick_d;

  vga_pix_div #(.CLK_DIV(P_CLK_DIV)) u_div (
    .clk      (clk),
    .rst      (rst),
    .pix_en_o (pix_en)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    // Registered so it lands together with the counters reaching (0, V_VE+1)
    frame_tick_d = pix_en && (h_q == H_LAST) && (v_q == V_VE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q          <= '0;
      v_q          <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vga.pix_en     = pix_en;
  assign vga.hCount     = h_q;
  assign vga.vCount     = v_q;
  assign vga.hSync      = ~(h_q < H_SYNCW);
  assign vga.vSync      = ~(v_q < V_SYNCW);
  assign vga.bright     = (h_q >= H_VS) && (h_q <= H_VE) && (v_q >= V_VS) && (v_q <= V_VE);
  assign vga.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default-timing instance for startup/line behaviour, shrunk-timing
// instance for whole-frame, tick and reset behaviour, both against a cycle-count model.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   ka = 0, kb = 0;
  int   n_pass = 0, n_total = 0;

  // Shrunk timing for instance b: 19 x 13 raster, 3 clk/pixel -> 741 clk/frame
  localparam int BD = 3, BHS = 4, BHB = 3, BHA = 10, BHF = 2;
  localparam int BVS = 2, BVB = 3, BVA = 6, BVF = 2;
  localparam int B_FRAME = (BHS+BHB+BHA+BHF) * (BVS+BVB+BVA+BVF) * BD;

  always #5 clk = ~clk;

  vga_timing_gen_if vif_a ();
  vga_timing_gen_if vif_b ();

  vga_timing_gen u_a (.clk(clk), .rst(rst_a), .vga(vif_a));

  vga_timing_gen #(
    .P_CLK_DIV(BD), .P_H_SYNC(BHS), .P_H_BP(BHB), .P_H_ACTIVE(BHA), .P_H_FP(BHF),
    .P_V_SYNC(BVS), .P_V_BP(BVB), .P_V_ACTIVE(BVA), .P_V_FP(BVF)
  ) u_b (.clk(clk), .rst(rst_b), .vga(vif_b));

  // Edges since reset release, per instance
  always @(posedge clk) ka <= rst_a ? 0 : ka + 1;
  always @(posedge clk) kb <= rst_b ? 0 : kb + 1;

  // Position is simply the number of pixel advances modulo the frame size
  function automatic logic [24:0] model(int k, int D, int HS, int HB, int HA, int HF,
                                        int VS, int VB, int VA, int VF);
    int ht, vt, adv, p, h, v;
    logic pix, br, hs, vs, ft;
    ht  = HS + HB + HA + HF;
    vt  = VS + VB + VA + VF;
    adv = (k >= 1) ? (k - 1) / D : 0;
    p   = adv % (ht * vt);
    h   = p % ht;
    v   = p / ht;
    pix = (k >= D) && (k % D == 0);
    ft  = (k > D) && ((k - 1) % D == 0) && (p == (VS + VB + VA) * ht);
    br  = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    hs  = !(h < HS);
    vs  = !(v < VS);
    return {pix, 10'(h), 10'(v), br, hs, vs, ft};
  endfunction

  function automatic logic [24:0] exp_a();
    return model(ka, 4, 96, 48, 640, 16, 2, 33, 480, 10);
  endfunction

  function automatic logic [24:0] exp_b();
    return model(kb, BD, BHS, BHB, BHA, BHF, BVS, BVB, BVA, BVF);
  endfunction

  function automatic logic [24:0] got_a();
    return {vif_a.pix_en, vif_a.hCount, vif_a.vCount, vif_a.bright,
            vif_a.hSync, vif_a.vSync, vif_a.frame_tick};
  endfunction

  function automatic logic [24:0] got_b();
    return {vif_b.pix_en, vif_b.hCount, vif_b.vCount, vif_b.bright,
            vif_b.hSync, vif_b.vSync, vif_b.frame_tick};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if (got_a() !== 25'd0) $display("FAIL reset_a got=%h exp=0", got_a());
    else n_pass++;
    n_total++;
    if (got_b() !== 25'd0) $display("FAIL reset_b got=%h exp=0", got_b());
    else n_pass++;
  endtask

  task automatic test_startup();
    int first_pix = -1;
    int ticks = 0;
    rst_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_total++;
      if (got_a() !== exp_a()) $display("FAIL startup k=%0d got=%h exp=%h", ka, got_a(), exp_a());
      else n_pass++;
      if (vif_a.pix_en && first_pix < 0) first_pix = ka;
      if (vif_a.frame_tick) ticks++;
    end
    n_total++;
    if (first_pix !== 4) $display("FAIL first_pix_en got=%0d exp=4", first_pix);
    else n_pass++;
    n_total++;
    if (ticks !== 0) $display("FAIL startup_tick got=%0d exp=0", ticks);
    else n_pass++;
  endtask

  task automatic test_line();
    int hs_low_line1 = 0;
    int wrap_seen = 0;
    int wrap_err = 0;
    logic pend = 1'b0;
    int pend_v = 0;
    while (ka < 3 * 3200) begin
      @(negedge clk);
      n_total++;
      if (got_a() !== exp_a()) $display("FAIL line k=%0d got=%h exp=%h", ka, got_a(), exp_a());
      else n_pass++;
      if (pend && vif_a.pix_en === 1'b0 && ka % 4 == 1) begin
        pend = 1'b0;
        wrap_seen++;
        if (vif_a.hCount !== 10'd0 || vif_a.vCount !== 10'(pend_v + 1)) wrap_err++;
      end
      if (vif_a.pix_en && vif_a.hCount == 10'd799) begin
        pend = 1'b1;
        pend_v = int'(vif_a.vCount);
      end
      if (vif_a.vCount == 10'd1 && vif_a.hSync == 1'b0) hs_low_line1++;
    end
    n_total++;
    if (hs_low_line1 !== 384) $display("FAIL hsync_low_clk got=%0d exp=384", hs_low_line1);
    else n_pass++;
    n_total++;
    if (wrap_seen < 2 || wrap_err !== 0)
      $display("FAIL line_wrap got=%0d/%0d wraps_ok exp=all", wrap_seen - wrap_err, wrap_seen);
    else n_pass++;
  endtask

  task automatic test_frame();
    int ticks = 0, tick_bright = 0, br_cnt = 0, br_frame = -1;
    int t_first = -1, t_second = -1;
    int first_br_h = -1, first_br_v = -1;
    rst_b = 1'b0;
    while (kb < 3 * B_FRAME + 10) begin
      @(negedge clk);
      n_total++;
      if (got_b() !== exp_b()) $display("FAIL frame k=%0d got=%h exp=%h", kb, got_b(), exp_b());
      else n_pass++;
      if (vif_b.bright && first_br_h < 0) begin
        first_br_h = int'(vif_b.hCount);
        first_br_v = int'(vif_b.vCount);
      end
      if (vif_b.frame_tick) begin
        ticks++;
        if (vif_b.bright) tick_bright++;
        if (ticks == 1) t_first = kb;
        if (ticks == 2) begin
          t_second = kb;
          br_frame = br_cnt;
        end
        br_cnt = 0;
      end
      if (vif_b.pix_en && vif_b.bright) br_cnt++;
    end
    n_total++;
    if (ticks !== 3) $display("FAIL tick_count got=%0d exp=3", ticks);
    else n_pass++;
    n_total++;
    if (t_second - t_first !== B_FRAME) $display("FAIL tick_period got=%0d exp=%0d", t_second - t_first, B_FRAME);
    else n_pass++;
    n_total++;
    if (br_frame !== BHA * BVA) $display("FAIL bright_count got=%0d exp=%0d", br_frame, BHA * BVA);
    else n_pass++;
    n_total++;
    if (tick_bright !== 0) $display("FAIL tick_while_bright got=%0d exp=0", tick_bright);
    else n_pass++;
    n_total++;
    if (first_br_h !== BHS + BHB || first_br_v !== BVS + BVB)
      $display("FAIL first_bright got=(%0d,%0d) exp=(%0d,%0d)", first_br_h, first_br_v, BHS + BHB, BVS + BVB);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int waited = 0;
    while (!(vif_b.hCount == 10'd9 && vif_b.vCount == 10'd5) && waited < 2 * B_FRAME) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (waited >= 2 * B_FRAME) $display("FAIL mid_reset_wait got=timeout exp=(9,5)");
    else n_pass++;
    rst_b = 1'b1;
    @(negedge clk);
    n_total++;
    if (got_b() !== 25'd0) $display("FAIL mid_reset got=%h exp=0", got_b());
    else n_pass++;
    rst_b = 1'b0;
    for (int i = 0; i < 4 * BD; i++) begin
      @(negedge clk);
      n_total++;
      if (got_b() !== exp_b()) $display("FAIL restart k=%0d got=%h exp=%h", kb, got_b(), exp_b());
      else n_pass++;
    end
  endtask

  task automatic test_random_reset();
    for (int it = 0; it < 20; it++) begin
      int run_len = int'($urandom_range(1, 900));
      int rst_len = int'($urandom_range(1, 3));
      for (int i = 0; i < run_len; i++) begin
        @(negedge clk);
        n_total++;
        if (got_b() !== exp_b()) $display("FAIL rand_run k=%0d got=%h exp=%h", kb, got_b(), exp_b());
        else n_pass++;
      end
      rst_b = 1'b1;
      for (int i = 0; i < rst_len; i++) begin
        @(negedge clk);
        n_total++;
        if (got_b() !== 25'd0) $display("FAIL rand_reset got=%h exp=0", got_b());
        else n_pass++;
      end
      rst_b = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_line();
    test_frame();
    test_mid_reset();
    test_random_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
